// File: rtl/alu_arbitro.sv
// alu_arbitro: two-requester round-robin sequencer in front of one shared,
// external combinational ALU.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   req_valid/ready    per-requester operation handshake (bit i = requester i)
//   req_a*/b*/op*      operands and op code of requester 0/1
//   resp_valid/ready   per-requester result handshake
//   resp_dato          registered ALU result, shared by both requesters
//   resp_err           op code was not one the ALU supports
//   alu_valA/B/op      operands and op code presented to the shared ALU
//   alu_resultado      combinational result returned by the shared ALU
//   ocupado            an operation is in flight (EJEC or RESP)
module alu_arbitro #(
    parameter int unsigned ANCHO = 32,
    parameter int unsigned OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [ANCHO-1:0] req_a0,
    input  logic [ANCHO-1:0] req_a1,
    input  logic [ANCHO-1:0] req_b0,
    input  logic [ANCHO-1:0] req_b1,
    input  logic [OP_W-1:0]  req_op0,
    input  logic [OP_W-1:0]  req_op1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [ANCHO-1:0] resp_dato,
    output logic             resp_err,
    output logic [ANCHO-1:0] alu_valA,
    output logic [ANCHO-1:0] alu_valB,
    output logic [OP_W-1:0]  alu_operacion,
    input  logic [ANCHO-1:0] alu_resultado,
    output logic             ocupado
);

    typedef enum logic [1:0] {
        LIBRE,
        EJEC,
        RESP
    } estado_t;

    estado_t          estado_q, estado_d;
    logic             prio_q, prio_d;
    logic             g_q, g_d;
    logic [ANCHO-1:0] a_q, a_d;
    logic [ANCHO-1:0] b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [ANCHO-1:0] dato_q, dato_d;
    logic             err_q, err_d;

    logic             gnt_ok;
    logic             gnt;
    logic             op_no_soportada;

    // Round-robin grant: the priority holder wins, otherwise the other one.
    always_comb begin
        gnt_ok = 1'b0;
        gnt    = prio_q;
        if (req_valid[prio_q]) begin
            gnt_ok = 1'b1;
            gnt    = prio_q;
        end else if (req_valid[~prio_q]) begin
            gnt_ok = 1'b1;
            gnt    = ~prio_q;
        end
    end

    always_comb begin
        case (op_q)
            OP_W'(0), OP_W'(1), OP_W'(2), OP_W'(3), OP_W'(4), OP_W'(5),
            OP_W'(6), OP_W'(7), OP_W'(8), OP_W'(13), OP_W'(15):
                op_no_soportada = 1'b0;
            default:
                op_no_soportada = 1'b1;
        endcase
    end

    always_comb begin
        estado_d   = estado_q;
        prio_d     = prio_q;
        g_d        = g_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        dato_d     = dato_q;
        err_d      = err_q;
        req_ready  = '0;
        resp_valid = '0;
        case (estado_q)
            LIBRE: begin
                // ready is only raised toward a valid requester, so a grant
                // is already a completed handshake.
                if (gnt_ok) begin
                    req_ready[gnt] = 1'b1;
                    g_d            = gnt;
                    a_d            = gnt ? req_a1  : req_a0;
                    b_d            = gnt ? req_b1  : req_b0;
                    op_d           = gnt ? req_op1 : req_op0;
                    estado_d       = EJEC;
                end
            end
            EJEC: begin
                dato_d   = alu_resultado;
                err_d    = op_no_soportada;
                estado_d = RESP;
            end
            RESP: begin
                resp_valid[g_q] = 1'b1;
                if (resp_ready[g_q]) begin
                    prio_d   = ~g_q;
                    estado_d = LIBRE;
                end
            end
            default: estado_d = LIBRE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= LIBRE;
            prio_q   <= 1'b0;
            g_q      <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            dato_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            prio_q   <= prio_d;
            g_q      <= g_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            dato_q   <= dato_d;
            err_q    <= err_d;
        end
    end

    assign alu_valA      = a_q;
    assign alu_valB      = b_q;
    assign alu_operacion = op_q;
    assign resp_dato     = dato_q;
    assign resp_err      = err_q;
    assign ocupado       = (estado_q != LIBRE);

endmodule

// File: tb/tb_alu_arbitro.sv
module tb_alu_arbitro;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] resp_dato, alu_valA, alu_valB, alu_resultado;
    logic        resp_err, ocupado;
    logic [3:0]  alu_operacion;

    always #5 clk = ~clk;

    alu_arbitro #(.ANCHO(32), .OP_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_dato(resp_dato), .resp_err(resp_err),
        .alu_valA(alu_valA), .alu_valB(alu_valB), .alu_operacion(alu_operacion),
        .alu_resultado(alu_resultado), .ocupado(ocupado)
    );

    // Stand-in for the external shared ALU.
    always_comb begin
        case (alu_operacion)
            4'd0:    alu_resultado = alu_valA + alu_valB;
            4'd1:    alu_resultado = alu_valA - alu_valB;
            4'd2:    alu_resultado = alu_valA & alu_valB;
            4'd3:    alu_resultado = alu_valA | alu_valB;
            4'd4:    alu_resultado = alu_valA ^ alu_valB;
            4'd5:    alu_resultado = alu_valA << alu_valB[4:0];
            4'd6:    alu_resultado = alu_valA >> alu_valB[4:0];
            4'd7:    alu_resultado = $unsigned($signed(alu_valA) >>> alu_valB[4:0]);
            4'd8:    alu_resultado = {31'b0, $signed(alu_valA) < $signed(alu_valB)};
            4'd13:   alu_resultado = {31'b0, alu_valA < alu_valB};
            4'd15:   alu_resultado = alu_valB;
            default: alu_resultado = '0;
        endcase
    end

    typedef struct {
        int          port;
        logic [31:0] dato;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Scoreboard monitor: every cycle a response is presented it must match
    // the head of the queue; the entry is retired on the handshake.
    always @(negedge clk) begin
        if (!rst && resp_valid != 2'b00) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", {30'b0, resp_valid}, 32'd0);
            end else begin
                chk("resp_port", {30'b0, resp_valid}, (q[0].port == 1) ? 32'd2 : 32'd1);
                chk("resp_dato", resp_dato, q[0].dato);
                chk("resp_err", {31'b0, resp_err}, {31'b0, q[0].err});
                if ((resp_valid & resp_ready) != 2'b00) void'(q.pop_front());
            end
        end
    end

    task automatic push(input int p, input logic [31:0] d, input logic e);
        exp_t x;
        x.port = p; x.dato = d; x.err = e;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Waits (bounded) until requester p is granted, then checks the whole
    // ready vector.
    task automatic wait_ready(input int p, input logic [1:0] exp_rdy);
        for (int i = 0; i < 20 && !req_ready[p]; i++) tick();
        chk("req_ready", {30'b0, req_ready}, {30'b0, exp_rdy});
    endtask

    task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] ed,
                         input logic ee, input bit do_push);
        if (p == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
        else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
        req_valid[p] = 1'b1;
        #1;
        wait_ready(p, (p == 1) ? 2'b10 : 2'b01);
        if (do_push) push(p, ed, ee);
        tick();
        req_valid[p] = 1'b0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ocupado"}, {31'b0, ocupado}, 32'd0);
        chk({nm, "_resp_valid"}, {30'b0, resp_valid}, 32'd0);
        chk({nm, "_req_ready"}, {30'b0, req_ready}, 32'd0);
        chk({nm, "_resp_dato"}, resp_dato, 32'd0);
        chk({nm, "_resp_err"}, {31'b0, resp_err}, 32'd0);
        chk({nm, "_alu_valA"}, alu_valA, 32'd0);
        chk({nm, "_alu_valB"}, alu_valB, 32'd0);
        chk({nm, "_alu_op"}, {28'b0, alu_operacion}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = '0; resp_ready = 2'b11;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        req_op0 = '0; req_op1 = '0;
        tick(); tick();
        rst = 1'b0;
        chk_idle("reset");

        // Single op, latency and ocupado window.
        issue(0, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0, 1'b1);
        chk("lat_T1_ocupado", {31'b0, ocupado}, 32'd1);
        chk("lat_T1_resp_valid", {30'b0, resp_valid}, 32'd0);
        tick();
        chk("lat_T2_resp_valid", {30'b0, resp_valid}, 32'd1);
        chk("lat_T2_ocupado", {31'b0, ocupado}, 32'd1);
        tick();
        chk("lat_done_ocupado", {31'b0, ocupado}, 32'd0);

        // Contention from reset: strict alternation.
        rst = 1'b1; tick(); rst = 1'b0;
        req_a0 = 32'd10; req_b0 = 32'd3; req_op0 = 4'd1;
        req_a1 = 32'hF0; req_b1 = 32'h0F; req_op1 = 4'd4;
        req_valid = 2'b11; #1;
        wait_ready(0, 2'b01);
        push(0, 32'd7, 1'b0);
        tick(); req_valid[0] = 1'b0;
        wait_ready(1, 2'b10);
        push(1, 32'hFF, 1'b0);
        tick();
        req_a0 = 32'hFF00; req_b0 = 32'h0FF0; req_op0 = 4'd2;
        req_a1 = 32'h1;    req_b1 = 32'h2;    req_op1 = 4'd3;
        req_valid = 2'b11; #1;
        wait_ready(0, 2'b01);
        push(0, 32'h0F00, 1'b0);
        tick(); req_valid[0] = 1'b0;
        wait_ready(1, 2'b10);
        push(1, 32'h3, 1'b0);
        tick(); req_valid = 2'b00;
        repeat (3) tick();

        // Backpressure with ready on the wrong bit.
        resp_ready = 2'b01;
        issue(1, 32'h8000_0000, 32'd4, 4'd7, 32'hF800_0000, 1'b0, 1'b1);
        tick();
        chk("bp_resp_valid", {30'b0, resp_valid}, 32'd2);
        req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = 4'd0; req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_stall_resp_valid", {30'b0, resp_valid}, 32'd2);
            chk("bp_stall_req_ready", {30'b0, req_ready}, 32'd0);
        end
        req_valid[0] = 1'b0;
        resp_ready = 2'b11;
        tick();
        chk("bp_done_resp_valid", {30'b0, resp_valid}, 32'd0);
        chk("bp_done_ocupado", {31'b0, ocupado}, 32'd0);

        // Unsupported op, then lui.
        issue(0, 32'd1, 32'd2, 4'b1010, 32'd0, 1'b1, 1'b1);
        tick(); tick();
        issue(0, 32'd0, 32'h1234_5000, 4'd15, 32'h1234_5000, 1'b0, 1'b1);
        tick(); tick();

        // Reset while in EJEC: no response, prio back to 0.
        issue(1, 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd1, 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_idle("midrst");
        req_a0 = 32'd100; req_b0 = 32'd23; req_op0 = 4'd0;
        req_valid = 2'b11; #1;
        chk("midrst_prio", {30'b0, req_ready}, 32'd1);
        push(0, 32'd123, 1'b0);
        tick(); req_valid = 2'b00;
        repeat (5) tick();

        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
